// File: rtl/sprite_fetch.sv
// rtl/sprite_fetch.sv - sprite ROM address generator and pixel sequencer
// Optional feature macro: SPRITE_FLIP_EN (frame-latched horizontal mirror input 'flip').
module sprite_fetch #(
    parameter int CORDW  = 16,
    parameter int WIDTH  = 4,
    parameter int SPR_W  = 32,
    parameter int SPR_H  = 20,
    parameter int SCALE  = 1,
    parameter int TRANSP = 0,
    parameter int DEPTH  = SPR_W * SPR_H,
    localparam int ADDRW = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame,
    input  logic                    line,
    input  logic signed [CORDW-1:0] sx,
    input  logic signed [CORDW-1:0] sy,
    input  logic signed [CORDW-1:0] sprx,
    input  logic signed [CORDW-1:0] spry,
`ifdef SPRITE_FLIP_EN
    input  logic                    flip,
`endif
    output logic [ADDRW-1:0]        rom_addr,
    input  logic [WIDTH-1:0]        rom_data,
    output logic [WIDTH-1:0]        pix,
    output logic                    pix_en
);
    localparam int XW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int YW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;

    typedef enum logic [2:0] {IDLE, WAIT_X, DRAW, LINE_END, DONE} state_t;
    state_t state, state_n;

    logic signed [CORDW-1:0] sprx_l, spry_l, spry_eff;
    logic                    armed;
    logic [XW-1:0]           xcnt;
    logic [SW-1:0]           xsub, ysub;
    logic [YW-1:0]           row;
    logic [ADDRW-1:0]        row_base, row_start, addr_next;
    logic                    d0, d1;
    logic                    start_row, go_draw, xsub_wrap, texel_last;
    logic                    row_end, row_adv, row_last;

`ifdef SPRITE_FLIP_EN
    logic flip_l;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     flip_l <= 1'b0;
        else if (frame) flip_l <= flip;
    end

    assign row_start = flip_l ? row_base + ADDRW'(SPR_W - 1) : row_base;
    assign addr_next = flip_l ? rom_addr - ADDRW'(1) : rom_addr + ADDRW'(1);
`else
    assign row_start = row_base;
    assign addr_next = rom_addr + ADDRW'(1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // frame forces IDLE, but a coincident line is still tested against the new spry
    always_comb begin
        state_n = state;
        if (frame) begin
            state_n = start_row ? WAIT_X : IDLE;
        end else begin
            case (state)
                IDLE:     if (start_row) state_n = WAIT_X;
                WAIT_X:   if (go_draw) state_n = DRAW;
                DRAW, LINE_END: begin
                    if (row_end)         state_n = row_last ? DONE : WAIT_X;
                    else if (texel_last) state_n = LINE_END;
                end
                DONE:     state_n = DONE;
                default:  state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        spry_eff   = frame ? spry : spry_l;
        start_row  = line && (frame || (state == IDLE && armed)) && (sy == spry_eff);
        go_draw    = !frame && (state == WAIT_X) && (sx == sprx_l);
        xsub_wrap  = (xsub == SW'(SCALE - 1));
        texel_last = (state == DRAW) && xsub_wrap && (xcnt == XW'(SPR_W - 1));
        row_end    = !frame && line && (state == DRAW || state == LINE_END);
        row_adv    = row_end && (ysub == SW'(SCALE - 1));
        row_last   = row_adv && (row == YW'(SPR_H - 1));
        pix        = d1 ? rom_data : '0;
        pix_en     = d1 && (rom_data != WIDTH'(TRANSP));
    end

    // armed stays low after reset so nothing is drawn from stale sprite coordinates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sprx_l   <= '0;
            spry_l   <= '0;
            armed    <= 1'b0;
            rom_addr <= '0;
            row_base <= '0;
            row      <= '0;
            ysub     <= '0;
            xcnt     <= '0;
            xsub     <= '0;
            d0       <= 1'b0;
            d1       <= 1'b0;
        end else begin
            d1 <= d0;
            if (frame) begin
                sprx_l   <= sprx;
                spry_l   <= spry;
                armed    <= 1'b1;
                row      <= '0;
                ysub     <= '0;
                row_base <= '0;
                d0       <= 1'b0;
            end else if (start_row) begin
                row_base <= '0;
            end else if (go_draw) begin
                rom_addr <= row_start;
                xcnt     <= '0;
                xsub     <= '0;
                d0       <= 1'b1;
            end else if (row_end) begin
                d0 <= 1'b0;
                if (row_adv) begin
                    ysub <= '0;
                    if (!row_last) begin
                        row      <= row + YW'(1);
                        row_base <= row_base + ADDRW'(SPR_W);
                    end
                end else begin
                    ysub <= ysub + SW'(1);
                end
            end else if (state == DRAW) begin
                if (texel_last) begin
                    d0 <= 1'b0;
                end else if (xsub_wrap) begin
                    xsub     <= '0;
                    xcnt     <= xcnt + XW'(1);
                    rom_addr <= addr_next;
                end else begin
                    xsub <= xsub + SW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_sprite_fetch.sv
// tb/tb_sprite_fetch.sv - randomized raster bench with a screen-space sprite model
module tb_sprite_fetch;
    localparam int SPR_W  = 32;
    localparam int SPR_H  = 20;
    localparam int DEPTH  = SPR_W * SPR_H;
    localparam int SX_MIN = -4;
    localparam int SX_MAX = 127;
    localparam int SY_MIN = -2;
    localparam int SY_MAX = 59;
`ifdef SPRITE_FLIP_EN
    localparam bit FLIP_ON = 1'b1;
`else
    localparam bit FLIP_ON = 1'b0;
`endif

    typedef struct {
        bit v;
        int addr;
        int fr;
        int sx;
        int sy;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame = 1'b0;
    logic line = 1'b0;
    logic signed [15:0] sx = '0, sy = '0, sprx = '0, spry = '0;
    logic flip = 1'b0;
    logic [9:0] addr1, addr2;
    logic [3:0] data1, data2, pix1, pix2;
    logic en1, en2;
    logic [3:0] rom [DEPTH];

    int checks = 0;
    int failures = 0;
    int fr_id = -1;
    int m_px = 0, m_py = 0, m_fl = 0;
    bit m_armed = 1'b0;
    rec_t h1 [3];
    rec_t h2 [3];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        data1 <= rom[addr1];
        data2 <= rom[addr2];
    end

    sprite_fetch #(.SCALE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .frame(frame), .line(line),
        .sx(sx), .sy(sy), .sprx(sprx), .spry(spry),
`ifdef SPRITE_FLIP_EN
        .flip(flip),
`endif
        .rom_addr(addr1), .rom_data(data1), .pix(pix1), .pix_en(en1)
    );

    sprite_fetch #(.SCALE(2)) u2 (
        .clk(clk), .rst_n(rst_n), .frame(frame), .line(line),
        .sx(sx), .sy(sy), .sprx(sprx), .spry(spry),
`ifdef SPRITE_FLIP_EN
        .flip(flip),
`endif
        .rom_addr(addr2), .rom_data(data2), .pix(pix2), .pix_en(en2)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Screen-space view: a texel is drawn where the beam lies inside the scaled sprite rectangle,
    // provided the sprite origin is reachable by the beam at all.
    function automatic rec_t mdl(input int x, input int y, input int px, input int py,
                                 input int fl, input int sc, input bit armed, input int fr);
        rec_t r;
        int col, rw;
        r.v = 1'b0; r.addr = 0; r.fr = fr; r.sx = x; r.sy = y;
        if (armed && px >= SX_MIN + 1 && px <= SX_MAX && py >= SY_MIN &&
            y >= py && y < py + SPR_H * sc && x >= px && x < px + SPR_W * sc) begin
            rw = (y - py) / sc;
            col = (x - px) / sc;
            r.v = 1'b1;
            r.addr = rw * SPR_W + ((fl != 0) ? (SPR_W - 1 - col) : col);
        end
        return r;
    endfunction

    function automatic rec_t blank();
        rec_t r;
        r.v = 1'b0; r.addr = 0; r.fr = -1; r.sx = 0; r.sy = 0;
        return r;
    endfunction

    always @(negedge clk) begin
        int e;
        if (!rst_n) begin
            chk("rst_addr1", addr1, 0);
            chk("rst_en1", en1, 0);
            chk("rst_pix1", pix1, 0);
            chk("rst_addr2", addr2, 0);
            chk("rst_en2", en2, 0);
            m_armed = 1'b0;
            for (int i = 0; i < 3; i++) begin
                h1[i] = blank();
                h2[i] = blank();
            end
        end else begin
            if (frame) begin
                m_px = sprx; m_py = spry;
                m_fl = FLIP_ON ? int'(flip) : 0;
                m_armed = 1'b1;
                fr_id++;
            end
            h1[2] = h1[1]; h1[1] = h1[0];
            h1[0] = mdl(sx, sy, m_px, m_py, m_fl, 1, m_armed, fr_id);
            h2[2] = h2[1]; h2[1] = h2[0];
            h2[0] = mdl(sx, sy, m_px, m_py, m_fl, 2, m_armed, fr_id);

            if (h1[1].v) chk("addr1", addr1, h1[1].addr);
            if (h2[1].v) chk("addr2", addr2, h2[1].addr);
            e = h1[2].v ? int'(rom[h1[2].addr]) : 0;
            chk("pix1", pix1, e);
            chk("en1", en1, (h1[2].v && e != 0) ? 1 : 0);
            e = h2[2].v ? int'(rom[h2[2].addr]) : 0;
            chk("pix2", pix2, e);
            chk("en2", en2, (h2[2].v && e != 0) ? 1 : 0);

            if (h1[1].fr == 0 && h1[1].sy == 5 && h1[1].sx == 40) chk("lit_row0_first", addr1, 0);
            if (h1[1].fr == 0 && h1[1].sy == 5 && h1[1].sx == 71) chk("lit_row0_last", addr1, 31);
            if (h1[1].fr == 0 && h1[1].sy == 6 && h1[1].sx == 40) chk("lit_row1_first", addr1, 32);
            if (h1[1].fr == 0 && h1[1].sy == 24 && h1[1].sx == 71) chk("lit_last_texel", addr1, 639);
            if (h1[2].fr == 0 && h1[2].sy == 5 && h1[2].sx == 40) chk("lit_first_pix_en", en1, 1);
            if (h1[2].fr == 0 && h1[2].sy == 5 && h1[2].sx == 44) chk("lit_transp_left", en1, 1);
            if (h1[2].fr == 0 && h1[2].sy == 5 && h1[2].sx == 45) chk("lit_transp", en1, 0);
            if (h1[2].fr == 0 && h1[2].sy == 5 && h1[2].sx == 46) chk("lit_transp_right", en1, 1);
            if (h2[1].fr == 0 && h2[1].sy == 5 && h2[1].sx == 41) chk("lit_s2_hold", addr2, 0);
            if (h2[1].fr == 0 && h2[1].sy == 6 && h2[1].sx == 42) chk("lit_s2_rowrep", addr2, 1);
            if (h2[1].fr == 0 && h2[1].sy == 44 && h2[1].sx == 103) chk("lit_s2_last", addr2, 639);
            if (h1[1].fr == 1 && h1[1].sy == 1 && h1[1].sx == 110) chk("lit_clip_restart", addr1, 32);
            if (h1[1].fr == 2 && h1[1].sy == -2 && h1[1].sx == -3)
                chk("lit_flip_row0", addr1, FLIP_ON ? 31 : 0);
            if (h1[1].fr == 2 && h1[1].sy == -1 && h1[1].sx == -3)
                chk("lit_flip_row1", addr1, FLIP_ON ? 63 : 32);
        end
    end

    task automatic run_frame(input int px, input int py, input int fl,
                             input int rst_y, input int rst_x);
        for (int y = SY_MIN; y <= SY_MAX; y++) begin
            for (int x = SX_MIN; x <= SX_MAX; x++) begin
                @(posedge clk);
                #1;
                sx = 16'(x);
                sy = 16'(y);
                line = (x == SX_MIN);
                frame = (x == SX_MIN && y == SY_MIN);
                if (frame) begin
                    sprx = 16'(px);
                    spry = 16'(py);
                    flip = fl[0];
                end else begin
                    sprx = 16'(int'($urandom_range(0, 300)) - 150);
                    spry = 16'(int'($urandom_range(0, 300)) - 150);
                    flip = 1'($urandom_range(0, 1));
                end
                if (y == rst_y && x == rst_x) rst_n = 1'b0;
                else if (y == rst_y && x == rst_x + 3) rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        rec_t p;
        for (int i = 0; i < DEPTH; i++) rom[i] = 4'($urandom_range(0, 15));
        rom[0] = 4'd3; rom[4] = 4'd7; rom[5] = 4'd0; rom[6] = 4'd9;
        for (int i = 0; i < 3; i++) begin
            h1[i] = blank();
            h2[i] = blank();
        end

        p = mdl(45, 5, 40, 5, 0, 1, 1'b1, 0);
        chk("pin_model_addr5", p.addr, 5);
        p = mdl(103, 44, 40, 5, 0, 2, 1'b1, 0);
        chk("pin_model_s2_last", p.addr, 639);
        p = mdl(72, 5, 40, 5, 0, 1, 1'b1, 0);
        chk("pin_model_outside", int'(p.v), 0);
        p = mdl(-3, -1, -3, -2, 1, 1, 1'b1, 0);
        chk("pin_model_flip", p.addr, 63);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_frame(40, 5, 0, -100, -100);
        run_frame(110, 0, 0, 3, 115);
        run_frame(-3, -2, 1, -100, -100);
        for (int f = 0; f < 3; f++)
            run_frame(int'($urandom_range(0, 143)) - 8, int'($urandom_range(0, 55)) - 5,
                      int'($urandom_range(0, 1)), -100, -100);

        @(posedge clk);
        #1;
        frame = 1'b1; line = 1'b1; sx = 16'(SX_MIN); sy = 16'(SY_MIN);
        sprx = -16'sd100; spry = -16'sd100;
        @(posedge clk);
        #1;
        frame = 1'b0; line = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sprite_fetch.md
Name: sprite_fetch

Overview:
- Address generator and pixel sequencer that sits directly upstream of the synchronous sprite ROM. It also consumes the ROM's data one cycle later.
- Tracks the beam position (sx, sy) against a sprite position latched once per frame and issues ROM addresses row by row, with optional integer scaling.
- Pipelines a draw flag to match the ROM's one-cycle read latency, then emits colour index plus a pixel-enable to the display mixer.

Parameters:
- CORDW, 16, width of signed screen coordinates
- WIDTH, 4, ROM word width (colour index)
- SPR_W, 32, sprite width in texels
- SPR_H, 20, sprite height in texels
- SCALE, 1, integer replication factor in both axes (1..8)
- TRANSP, 0, colour index treated as transparent
- DEPTH, SPR_W*SPR_H, ROM depth (localparam ADDRW = $clog2(DEPTH))

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame  in  1  one-cycle pulse at frame start; latches sprx/spry
- line  in  1  one-cycle pulse at the start of each scan line (before the active area)
- sx  in  CORDW signed  current horizontal beam position
- sy  in  CORDW signed  current vertical beam position
- sprx  in  CORDW signed  sprite left edge in screen pixels
- spry  in  CORDW signed  sprite top edge in screen pixels
- rom_addr  out  ADDRW  registered address to the sprite ROM
- rom_data  in  WIDTH  ROM read data, valid one cycle after rom_addr
- pix  out  WIDTH  colour index for the pixel
- pix_en  out  1  high when the sprite covers the pixel and it is not TRANSP

Behaviour:
- Reset: state=IDLE, rom_addr=0, row/sub counters=0, draw pipeline=0, pix_en=0. pix is rom_data gated by the pipeline flag, so pix=0 while in reset.
- frame: latch sprx_l, spry_l; row=0; ysub=0; state→IDLE. Aborts any draw in progress.
- frame and line in the same cycle: latch first; the line test uses the new values.
- States:
  - IDLE: on line with sy==spry_l → WAIT_X; row_base=0.
  - WAIT_X: when sx==sprx_l → DRAW; rom_addr<=row_base; xcnt=0; xsub=0.
  - DRAW: each cycle xsub++. On xsub==SCALE-1: xsub=0, xcnt++, rom_addr++. When xcnt==SPR_W-1 and xsub==SCALE-1 → LINE_END.
  - LINE_END: on the next line pulse, ysub++. On ysub==SCALE-1: ysub=0, row++, row_base+=SPR_W. When row==SPR_H-1 and ysub==SCALE-1 → DONE, otherwise → WAIT_X.
  - DONE: hold until frame.
  - A line pulse arriving while in DRAW (sprite clipped at the right edge) is treated as the LINE_END transition.
- Draw flag:
  - d0 is registered high for each cycle rom_addr carries a sprite texel (first texel issued the cycle after sx==sprx_l).
  - d1<=d0 aligns with rom_data.
  - pix=d1?rom_data:0; pix_en=d1 && rom_data!=TRANSP.
  - Total latency: pixel for beam position sx appears 2 cycles after sx; the parent delays its own sx-derived signals by 2.
- Widths: row_base < DEPTH at all times; no rom_addr wrap in normal operation. Sprites off-screen (never matched) simply produce no output.
- Negative sprx/spry are valid; a sprite partially above the screen is not drawn (no match).

Optional Feature:
- Macro SPRITE_FLIP_EN adds input port flip (1 bit, latched on frame).
- When the latched flip is set, each row is read mirrored: the row start address is row_base+SPR_W-1 and the address decrements instead of increments. Timing and scaling are unchanged.
- Without the macro, there is no flip port and addresses always increment.

Test Plan:
- Reset asserted mid-DRAW (SCALE=1) → rom_addr=0, pix_en=0 immediately; after release no output until the next frame plus a line with sy==spry.
- frame with sprx=100, spry=50, SCALE=1; raster line 50 → rom_addr 0..31 on cycles following sx=100..131; pix_en first high 2 cycles after sx=100; line 51 starts at addr 32.
- SCALE=2, sprx=10 → each address held 2 cycles, each row repeated on 2 lines; last texel addr 639 on line spry+39.
- ROM word equal to TRANSP=0 at addr 5 → pix_en low for that pixel only, pix_en high on both neighbours.
- sprx=620 with 640-wide line: line pulse mid-DRAW → next line restarts at row_base+32, no address carry-over.
- SPRITE_FLIP_EN, flip=1 → row 0 addresses 31 down to 0; row 1 addresses 63 down to 32.
